// File: rtl/lookup_map_nch.sv
// Double-banked per-channel LUT mapper for a y/u/v pixel stream. The DI port loads
// the shadow bank and requests a swap that takes effect on the next frame start.
`ifndef TERM_GammaLookup
`define TERM_GammaLookup 16'h0010
`endif
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif

module lookup_map_nch #(
  parameter int unsigned PIXEL_WIDTH   = 10,
  parameter int unsigned DI_DATA_WIDTH = 16,
  parameter int unsigned NUM_CH        = 3,
  parameter logic [15:0] TERM_ADDR     = `TERM_GammaLookup
) (
  input  logic                          pixclk,
  input  logic                          resetb,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [15:0]                   di_term_addr,
  input  logic [31:0]                   di_reg_addr,
  input  logic                          di_read_mode,
  input  logic                          di_read_req,
  input  logic                          di_read,
  input  logic                          di_write_mode,
  input  logic                          di_write,
  input  logic [DI_DATA_WIDTH-1:0]      di_reg_datai,
  output logic                          di_read_rdy,
  output logic [DI_DATA_WIDTH-1:0]      di_reg_datao,
  output logic                          di_write_rdy,
  output logic [15:0]                   di_transfer_status,
  output logic                          di_en,
  input  logic                          dvi,
  input  logic [`DTYPE_WIDTH-1:0]       dtypei,
  input  logic [PIXEL_WIDTH-1:0]        y,
  input  logic signed [PIXEL_WIDTH-1:0] u,
  input  logic signed [PIXEL_WIDTH-1:0] v,
  input  logic [15:0]                   meta_datai,
  output logic                          dvo,
  output logic [`DTYPE_WIDTH-1:0]       dtypeo,
  output logic [PIXEL_WIDTH-1:0]        yo,
  output logic signed [PIXEL_WIDTH-1:0] uo,
  output logic signed [PIXEL_WIDTH-1:0] vo,
  output logic [15:0]                   meta_datao
);
  localparam int unsigned DEPTH = 1 << PIXEL_WIDTH;
  typedef logic [PIXEL_WIDTH-1:0] pix_t;

  logic       active_bank, swap_pending, swap_now, pix_bank;
  logic       term_hit, entry_wr, ctrl_set, wr_drop;
  logic [1:0] di_ch;
  pix_t       di_idx;
  pix_t       pix_in [3];
  pix_t       pix_idx [3];
  pix_t       pix_lut [3];
  pix_t       shd_rd [3];
  logic [2:0] en_ch;
  logic [DI_DATA_WIDTH-1:0] rd_data, rd_data1;
  logic       rd_v1;

  logic                    dv1;
  logic [`DTYPE_WIDTH-1:0] dtype1;
  logic [15:0]             meta1;
  pix_t                    pix1 [3];
  pix_t                    lut1 [3];
  logic [2:0]              en1;

  logic unused_ok;
  assign unused_ok = ^{di_read_mode, di_read, di_write_mode,
                       di_reg_addr[30:PIXEL_WIDTH+2], di_reg_datai};

  assign term_hit = (di_term_addr == TERM_ADDR);
  assign di_ch    = di_reg_addr[PIXEL_WIDTH+1:PIXEL_WIDTH];
  assign di_idx   = di_reg_addr[PIXEL_WIDTH-1:0];
  assign entry_wr = term_hit && di_write && !di_reg_addr[31];
  assign ctrl_set = term_hit && di_write && di_reg_addr[31] && di_reg_datai[0];
  assign wr_drop  = entry_wr && (32'(di_ch) >= NUM_CH);
  assign swap_now = dvi && (dtypei == `DTYPE_FRAME_START) && swap_pending;
  // The frame-start beat that triggers the swap already reads the new bank.
  assign pix_bank = active_bank ^ swap_now;

  assign pix_in[0]  = y;
  assign pix_in[1]  = u;
  assign pix_in[2]  = v;
  assign pix_idx[0] = y;
  assign pix_idx[1] = {~u[PIXEL_WIDTH-1], u[PIXEL_WIDTH-2:0]};
  assign pix_idx[2] = {~v[PIXEL_WIDTH-1], v[PIXEL_WIDTH-2:0]};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    if (c < NUM_CH) begin : g_lut
      pix_t bank_a [DEPTH];
      pix_t bank_b [DEPTH];
      // Writes use the registered bank, so a write coinciding with a swap
      // lands in the bank that is becoming active.
      always_ff @(posedge pixclk) begin
        if (entry_wr && di_ch == 2'(c)) begin
          if (active_bank) bank_a[di_idx] <= di_reg_datai[PIXEL_WIDTH-1:0];
          else             bank_b[di_idx] <= di_reg_datai[PIXEL_WIDTH-1:0];
        end
      end
      assign pix_lut[c] = pix_bank ? bank_b[pix_idx[c]] : bank_a[pix_idx[c]];
      assign shd_rd[c]  = active_bank ? bank_a[di_idx] : bank_b[di_idx];
      assign en_ch[c]   = enable[c];
    end else begin : g_pass
      assign pix_lut[c] = '0;
      assign shd_rd[c]  = '0;
      assign en_ch[c]   = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (di_reg_addr[31])
      rd_data[1:0] = {active_bank, swap_pending};
    else if (32'(di_ch) < NUM_CH)
      rd_data[PIXEL_WIDTH-1:0] = shd_rd[di_ch];
  end

  always_ff @(posedge pixclk or negedge resetb) begin
    if (!resetb) begin
      swap_pending       <= 1'b0;
      active_bank        <= 1'b0;
      rd_v1              <= 1'b0;
      rd_data1           <= '0;
      di_read_rdy        <= 1'b0;
      di_reg_datao       <= '0;
      di_write_rdy       <= 1'b0;
      di_en              <= 1'b0;
      di_transfer_status <= '0;
    end else begin
      swap_pending <= (swap_pending && !swap_now) || ctrl_set;
      active_bank  <= active_bank ^ swap_now;
      rd_v1        <= term_hit && di_read_req;
      rd_data1     <= rd_data;
      di_read_rdy  <= rd_v1;
      if (rd_v1) di_reg_datao <= rd_data1;
      di_write_rdy <= term_hit;
      di_en        <= term_hit;
      di_transfer_status <= !term_hit ? 16'hffff : (wr_drop ? 16'h0001 : 16'h0000);
    end
  end

  always_ff @(posedge pixclk or negedge resetb) begin
    if (!resetb) begin
      dv1        <= 1'b0;
      dtype1     <= '0;
      meta1      <= '0;
      en1        <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      meta_datao <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        pix1[c] <= '0;
        lut1[c] <= '0;
      end
    end else begin
      dv1    <= dvi;
      dtype1 <= dtypei;
      meta1  <= meta_datai;
      en1    <= en_ch;
      for (int unsigned c = 0; c < 3; c++) begin
        pix1[c] <= pix_in[c];
        lut1[c] <= pix_lut[c];
      end
      dvo        <= dv1;
      dtypeo     <= dtype1;
      meta_datao <= meta1;
      yo         <= en1[0] ? lut1[0] : pix1[0];
      uo         <= en1[1] ? lut1[1] : pix1[1];
      vo         <= en1[2] ? lut1[2] : pix1[2];
    end
  end

endmodule

// File: tb/tb_lookup_map_nch.sv
// Randomised bench for lookup_map_nch: an array model of both banks predicts every
// pixel beat and DI read; a monitor pops the predictions when the DUT presents them.
`ifndef TERM_GammaLookup
`define TERM_GammaLookup 16'h0010
`endif
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif

module tb_lookup_map_nch;
  localparam int PW    = 10;
  localparam int DW    = 16;
  localparam int NCH   = 3;
  localparam int DEPTH = 1 << PW;
  localparam int DTW   = `DTYPE_WIDTH;
  localparam logic [15:0]    TERM = `TERM_GammaLookup;
  localparam logic [DTW-1:0] FS   = `DTYPE_FRAME_START;

  logic                 pixclk = 1'b0;
  logic                 resetb = 1'b0;
  logic [NCH-1:0]       enable = '0;
  logic [15:0]          di_term_addr = '0;
  logic [31:0]          di_reg_addr = '0;
  logic                 di_read_mode = 1'b0, di_read_req = 1'b0, di_read = 1'b0;
  logic                 di_write_mode = 1'b0, di_write = 1'b0;
  logic [DW-1:0]        di_reg_datai = '0;
  logic                 di_read_rdy, di_write_rdy, di_en;
  logic [DW-1:0]        di_reg_datao;
  logic [15:0]          di_transfer_status;
  logic                 dvi = 1'b0;
  logic [DTW-1:0]       dtypei = '0;
  logic [PW-1:0]        y = '0;
  logic signed [PW-1:0] u = '0, v = '0;
  logic [15:0]          meta_datai = '0;
  logic                 dvo;
  logic [DTW-1:0]       dtypeo;
  logic [PW-1:0]        yo;
  logic signed [PW-1:0] uo, vo;
  logic [15:0]          meta_datao;

  lookup_map_nch #(.PIXEL_WIDTH(PW), .DI_DATA_WIDTH(DW), .NUM_CH(NCH), .TERM_ADDR(TERM)) dut (
    .pixclk(pixclk), .resetb(resetb), .enable(enable),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao), .di_write_rdy(di_write_rdy),
    .di_transfer_status(di_transfer_status), .di_en(di_en),
    .dvi(dvi), .dtypei(dtypei), .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo), .dtypeo(dtypeo), .yo(yo), .uo(uo), .vo(vo), .meta_datao(meta_datao)
  );

  always #5 pixclk = ~pixclk;

  int cyc = 0;
  always @(posedge pixclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int             due;
    logic [DTW-1:0] dt;
    logic [15:0]    meta;
    logic [PW-1:0]  ye, ue, ve;
  } pix_exp_t;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  pix_exp_t pq[$];
  rd_exp_t  rq[$];

  // Behavioural model: lut[bank][ch][entry], bank 0 = A.
  int lut [2][NCH][DEPTH];
  bit m_act = 1'b0;
  bit m_sp  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Applies the current DUT inputs for one clock, updating the model first.
  task automatic cycle();
    bit hit, swap, set, bank;
    int ch, idx, iu, iv;
    logic [15:0] exp_st;
    pix_exp_t pe;
    rd_exp_t  re;
    hit = (di_term_addr == TERM);
    ch  = int'(di_reg_addr[PW+1:PW]);
    idx = int'(di_reg_addr[PW-1:0]);
    if (hit && di_read_req) begin
      re.due = cyc + 2;
      if (di_reg_addr[31])   re.data = DW'({m_act, m_sp});
      else if (ch < NCH)     re.data = DW'(lut[!m_act][ch][idx]);
      else                   re.data = '0;
      rq.push_back(re);
    end
    swap = dvi && (dtypei == FS) && m_sp;
    if (dvi) begin
      bank = m_act ^ swap;
      iu = int'(u) + DEPTH / 2;
      iv = int'(v) + DEPTH / 2;
      pe.due  = cyc + 2;
      pe.dt   = dtypei;
      pe.meta = meta_datai;
      pe.ye   = enable[0] ? PW'(lut[bank][0][int'(y)]) : y;
      pe.ue   = enable[1] ? PW'(lut[bank][1][iu]) : u;
      pe.ve   = enable[2] ? PW'(lut[bank][2][iv]) : v;
      pq.push_back(pe);
    end
    exp_st = !hit ? 16'hffff : ((di_write && !di_reg_addr[31] && ch >= NCH) ? 16'h0001 : 16'h0000);
    if (hit && di_write && !di_reg_addr[31] && ch < NCH)
      lut[!m_act][ch][idx] = int'(di_reg_datai[PW-1:0]);
    set  = hit && di_write && di_reg_addr[31] && di_reg_datai[0];
    m_sp = (m_sp && !swap) || set;
    m_act = m_act ^ swap;
    @(posedge pixclk);
    #1;
    chk("transfer_status", 32'(di_transfer_status), 32'(exp_st));
    chk("di_en", 32'(di_en), 32'(hit));
    chk("di_write_rdy", 32'(di_write_rdy), 32'(hit));
    di_write    = 1'b0;
    di_read_req = 1'b0;
    dvi         = 1'b0;
  endtask

  task automatic di_wr(input logic [31:0] addr, input logic [DW-1:0] data);
    di_term_addr = TERM;
    di_reg_addr  = addr;
    di_reg_datai = data;
    di_write     = 1'b1;
  endtask

  task automatic di_rd(input logic [31:0] addr);
    di_term_addr = TERM;
    di_reg_addr  = addr;
    di_read_req  = 1'b1;
  endtask

  task automatic beat(input logic [DTW-1:0] dt, input logic [PW-1:0] yy,
                      input logic [PW-1:0] uu, input logic [PW-1:0] vv, input logic [2:0] en);
    dvi        = 1'b1;
    dtypei     = dt;
    y          = yy;
    u          = uu;
    v          = vv;
    enable     = en;
    meta_datai = 16'($urandom);
  endtask

  task automatic fill_shadow(input bit ramp_y);
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < DEPTH; i++) begin
        di_wr({1'b0, 19'd0, 2'(c), 10'(i)},
              (ramp_y && c == 0) ? DW'(DEPTH - 1 - i) : DW'($urandom_range(0, DEPTH - 1)));
        cycle();
      end
  endtask

  always @(negedge pixclk) begin
    if (resetb) begin
      if (dvo) begin
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL pix_unexpected actual=dvo=1 required=no beat pending");
        end else begin
          pix_exp_t e;
          e = pq.pop_front();
          if (e.due != cyc || dtypeo !== e.dt || meta_datao !== e.meta ||
              yo !== e.ye || uo !== e.ue || vo !== e.ve) begin
            failures++;
            $display("FAIL pix_beat actual=cyc%0d dt=%0h meta=%0h y=%0d u=%0d v=%0d required=cyc%0d dt=%0h meta=%0h y=%0d u=%0d v=%0d",
                     cyc, dtypeo, meta_datao, yo, uo, vo, e.due, e.dt, e.meta, e.ye, e.ue, e.ve);
          end
        end
      end
      if (di_read_rdy) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL read_unexpected actual=rdy=1 required=no read pending");
        end else begin
          rd_exp_t r;
          r = rq.pop_front();
          if (r.due != cyc || di_reg_datao !== r.data) begin
            failures++;
            $display("FAIL read_data actual=cyc%0d data=%0h required=cyc%0d data=%0h",
                     cyc, di_reg_datao, r.due, r.data);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge pixclk);
    #1;
    chk("reset_dvo", 32'(dvo), 0);
    chk("reset_yo", 32'(yo), 0);
    chk("reset_rdy", 32'(di_read_rdy), 0);
    chk("reset_status", 32'(di_transfer_status), 0);
    chk("reset_di_en", 32'(di_en), 0);
    resetb = 1'b1;

    di_term_addr = 16'h0bad;
    cycle();
    di_term_addr = TERM;
    cycle();

    // Load shadow B with a descending y ramp, swap on a frame start, then map y=5.
    fill_shadow(1'b1);
    di_wr(32'h8000_0000, 16'h0001); cycle();
    beat(FS, 10'd3, 10'd0, 10'd0, 3'b000); cycle();
    beat(4'h2, 10'd5, 10'($urandom), 10'($urandom), 3'b111); cycle();
    di_rd(32'h8000_0000); cycle();
    // Load the other bank and swap back so every entry of both banks is known.
    fill_shadow(1'b0);
    di_wr(32'h8000_0000, 16'h0001); cycle();
    beat(FS, 10'd9, 10'd1, 10'd2, 3'b111); cycle();

    // Pass-through with all channels disabled, including negative chroma.
    beat(4'h3, 10'd100, -10'sd3, 10'sd7, 3'b000); cycle();
    // Dropped write to a channel that does not exist.
    di_wr({1'b0, 19'd0, 2'd3, 10'd5}, 16'h0123); cycle();
    cycle();
    beat(4'h2, 10'd5, 10'd5, 10'd5, 3'b111); cycle();

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      beat(($urandom_range(0, 7) == 0) ? FS : DTW'($urandom_range(2, 15)),
           10'($urandom), 10'($urandom), 10'($urandom), 3'($urandom));
      dvi = ($urandom_range(0, 3) != 0);
      if (r < 20)      di_wr({1'b0, 19'd0, 2'($urandom_range(0, 3)), 10'($urandom)}, 16'($urandom));
      else if (r < 26) di_wr(32'h8000_0000, 16'($urandom));
      else if (r < 36) di_rd(32'h8000_0000);
      else if (r < 50) di_rd({1'b0, 19'd0, 2'($urandom_range(0, 2)), 10'($urandom)});
      di_term_addr = ($urandom_range(0, 9) == 0) ? 16'h0bad : TERM;
      cycle();
    end

    // Flush any pending swap, then write the shadow without requesting one.
    beat(FS, 10'd0, 10'd0, 10'd0, 3'b000); cycle();
    di_wr({1'b0, 19'd0, 2'd0, 10'd50}, 16'd777); cycle();
    beat(FS, 10'd50, 10'd0, 10'd0, 3'b001); cycle();
    beat(4'h2, 10'd50, 10'd0, 10'd0, 3'b001); cycle();

    // Set swap_pending again on the very frame start that consumes it.
    di_wr(32'h8000_0000, 16'h0001); cycle();
    di_wr(32'h8000_0000, 16'h0001);
    beat(FS, 10'd50, 10'd0, 10'd0, 3'b111); cycle();
    di_rd(32'h8000_0000); cycle();
    beat(FS, 10'd50, 10'd0, 10'd0, 3'b111); cycle();
    di_rd(32'h8000_0000); cycle();

    // Entry write coincident with a swap lands in the newly active bank.
    di_wr(32'h8000_0000, 16'h0001); cycle();
    di_wr({1'b0, 19'd0, 2'd0, 10'd77}, 16'd321);
    beat(FS, 10'd1, 10'd0, 10'd0, 3'b111); cycle();
    beat(4'h2, 10'd77, 10'd0, 10'd0, 3'b111); cycle();

    // Reset mid-stream while beats are in flight.
    beat(4'h2, 10'd11, 10'd0, 10'd0, 3'b000); cycle();
    beat(4'h2, 10'd12, 10'd0, 10'd0, 3'b000); cycle();
    #2;
    resetb = 1'b0;
    #1;
    chk("midreset_dvo", 32'(dvo), 0);
    chk("midreset_yo", 32'(yo), 0);
    pq.delete();
    rq.delete();
    m_act = 1'b0;
    m_sp  = 1'b0;
    repeat (2) @(posedge pixclk);
    #1;
    resetb = 1'b1;
    cycle();
    chk("post_reset_dvo", 32'(dvo), 0);
    di_rd(32'h8000_0000); cycle();
    beat(4'h2, 10'd42, -10'sd1, 10'sd1, 3'b000); cycle();
    repeat (4) cycle();

    chk("pix_queue_drained", 32'(pq.size()), 0);
    chk("read_queue_drained", 32'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
